regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of each register and every data port, in bits.
REQ-002 Parameter ADDR_WIDTH, default 5: width of each address port; register count is 2**ADDR_WIDTH (32 at default).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 write_enable  input  1  when high, the write port commits on the next rising clk edge.
REQ-006 write_data  input  DATA_WIDTH  value to be written.
REQ-007 write_address  input  ADDR_WIDTH  destination register index.
REQ-008 read_address1  input  ADDR_WIDTH  register index for read port 1.
REQ-009 read_address2  input  ADDR_WIDTH  register index for read port 2.
REQ-010 read_data1  output  DATA_WIDTH  contents of register read_address1.
REQ-011 read_data2  output  DATA_WIDTH  contents of register read_address2.

Function
REQ-012 The block SHALL hold 2**ADDR_WIDTH registers of DATA_WIDTH bits each, with one write port and two independent read ports.
REQ-013 On a rising clk edge with rst_n high and write_enable high, register[write_address] SHALL take the value of write_data.
REQ-014 With write_enable low, no register SHALL change on a clk edge.
REQ-015 Register 0 SHALL be hardwired to zero: writes to address 0 are discarded, and reads of address 0 always return 0.
REQ-016 Reads SHALL be combinational (zero-cycle latency): read_dataN reflects the current address and register contents within the same cycle.
REQ-017 Both read ports SHALL operate concurrently and may address the same register, each returning an identical value.
REQ-018 A write SHALL become visible on read ports starting from the clock edge that commits it; same-cycle read-during-write behaviour is governed by REQ-023/REQ-024.
REQ-019 Back-to-back writes to the same address on consecutive cycles SHALL leave the last written value.

Reset
REQ-020 While rst_n is low, every register SHALL be cleared to 0 asynchronously, independent of clk.
REQ-021 While rst_n is low, writes SHALL be ignored, and both read_data outputs SHALL read 0 for any address.
REQ-022 Reset asserted in the same cycle as a write SHALL win: the register holds 0 after rst_n is released.

Configuration
REQ-023 With macro REGFILE_BYPASS_EN defined: when write_enable is high, write_address is non-zero, and read_addressN equals write_address, read_dataN SHALL combinationally return write_data (write-through forwarding).
REQ-024 With REGFILE_BYPASS_EN undefined: read_dataN SHALL return the stored (pre-write) value until the write commits at the clock edge.

Verification
REQ-025 Reset: hold rst_n low, then release; read addresses 0..31 on both ports -> all read 00000000.
REQ-026 Basic write/read: write ABCDEF47 to reg 5, then deassert write_enable, set read_address1=5 and read_address2=0 -> read_data1=ABCDEF47, read_data2=00000000.
REQ-027 Reg 0 protection: write FFFFFFFF to address 0 -> both ports read 00000000 at address 0.
REQ-028 Dual-port/walk: write each register i (1..31) with value 1000_0000+i, then read pairs (i, 32-i) -> each port returns its own register's value.
REQ-029 Write-enable gating and async reset: present write_data=12345678 at address 7 with write_enable=0 -> reg 7 is unchanged. Then write it with write_enable=1. Then pulse rst_n low between clock edges -> reg 7 reads 00000000 immediately, before the next clk edge.
REQ-030 Read-during-write: read reg 9 (holding 00000011) while writing 00000022 to it -> read returns 00000022 in the same cycle with REGFILE_BYPASS_EN defined, or 00000011 without it. In both builds, the read returns 00000022 after the edge.

Source files
------------

// File: rtl/regfile_if.sv
// Register-file access bus: one write port and two combinational read ports.
interface regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] write_data;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [ADDR_WIDTH-1:0] read_address1;
  logic [ADDR_WIDTH-1:0] read_address2;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;

  modport master (
    output write_enable, write_data, write_address, read_address1, read_address2,
    input  read_data1, read_data2
  );

  modport slave (
    input  write_enable, write_data, write_address, read_address1, read_address2,
    output read_data1, read_data2
  );
endinterface

// File: rtl/regfile.sv
// 2**ADDR_WIDTH x DATA_WIDTH register file, register 0 hardwired to zero, async clear.
// Define REGFILE_BYPASS_EN to forward write_data to matching read ports in the write cycle.
module regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  regfile_if.slave   bus
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Register 0 has no storage; indices start at 1.
  logic [DATA_WIDTH-1:0] regs_reg [1:NUM_REGS-1];
  logic [ADDR_WIDTH-1:0] rd_addr  [2];
  logic [DATA_WIDTH-1:0] rd_data  [2];

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs_reg[gi] <= '0;
        end else if (bus.write_enable && bus.write_address == ADDR_WIDTH'(gi)) begin
          regs_reg[gi] <= bus.write_data;
        end
      end
    end
  endgenerate

  assign rd_addr[0]     = bus.read_address1;
  assign rd_addr[1]     = bus.read_address2;
  assign bus.read_data1 = rd_data[0];
  assign bus.read_data2 = rd_data[1];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      // Reset forces zero even with a pending write so the bypass cannot leak data.
      always_comb begin
        rd_data[gi] = '0;
        if (rst_n && rd_addr[gi] != '0) begin
          rd_data[gi] = regs_reg[rd_addr[gi]];
          if (BYPASS && bus.write_enable && bus.write_address == rd_addr[gi]) begin
            rd_data[gi] = bus.write_data;
          end
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: reference model plus queue of expected read values.
module tb_regfile;
  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  logic [31:0] model [32];
  string       tag_q [$];
  logic [31:0] exp_q [$];

  regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf_bus ();

  regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rf_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_reads(input logic [4:0] a1, input logic [4:0] a2);
    rf_bus.read_address1 = a1;
    rf_bus.read_address2 = a2;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] e1, input logic [31:0] e2);
    tag_q.push_back(tag);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
  endtask

  // Expected values are taken from the bench's own model, never from the DUT.
  task automatic push_model(input string tag);
    push_exp(tag, model[rf_bus.read_address1], model[rf_bus.read_address2]);
  endtask

  task automatic settle_and_check();
    string       tag;
    logic [31:0] e1;
    logic [31:0] e2;
    #1;
    while (tag_q.size() > 0) begin
      tag = tag_q.pop_front();
      e1  = exp_q.pop_front();
      e2  = exp_q.pop_front();
      tests_run++;
      assert (rf_bus.read_data1 === e1) else begin
        tests_failed++;
        $error("FAIL %s port1 addr=%0d got %h expected %h", tag, rf_bus.read_address1, rf_bus.read_data1, e1);
      end
      tests_run++;
      assert (rf_bus.read_data2 === e2) else begin
        tests_failed++;
        $error("FAIL %s port2 addr=%0d got %h expected %h", tag, rf_bus.read_address2, rf_bus.read_data2, e2);
      end
      $display("[TB] %s a1=%0d d1=%h a2=%0d d2=%h", tag, rf_bus.read_address1, rf_bus.read_data1,
               rf_bus.read_address2, rf_bus.read_data2);
    end
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    rf_bus.write_enable  = 1'b1;
    rf_bus.write_address = addr;
    rf_bus.write_data    = data;
    @(posedge clk);
    if (addr != 5'd0) model[addr] = data;
    #1;
    rf_bus.write_enable = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst_n = 1'b0;
    rf_bus.write_enable  = 1'b0;
    rf_bus.write_data    = 32'h0;
    rf_bus.write_address = 5'd0;
    set_reads(5'd0, 5'd0);

    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      set_reads(5'(i), 5'(31 - i));
      push_exp("reset", 32'h0, 32'h0);
      settle_and_check();
    end

    // Basic write/read
    do_write(5'd5, 32'hABCDEF47);
    set_reads(5'd5, 5'd0);
    push_exp("basic", 32'hABCDEF47, 32'h0);
    settle_and_check();

    // Register 0 protection, including the cycle of the write itself
    @(negedge clk);
    rf_bus.write_enable  = 1'b1;
    rf_bus.write_address = 5'd0;
    rf_bus.write_data    = 32'hFFFFFFFF;
    set_reads(5'd0, 5'd0);
    push_exp("r0_during", 32'h0, 32'h0);
    settle_and_check();
    @(posedge clk);
    #1;
    rf_bus.write_enable = 1'b0;
    push_exp("r0_after", 32'h0, 32'h0);
    settle_and_check();

    // Walk every register, then dual-port pairs
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'h1000_0000 + 32'(i));
    for (int i = 1; i < 32; i++) begin
      set_reads(5'(i), 5'(32 - i));
      push_model("walk");
      settle_and_check();
    end

    // Back-to-back writes, last value wins
    do_write(5'd12, 32'hDEAD0001);
    do_write(5'd12, 32'hDEAD0002);
    set_reads(5'd12, 5'd12);
    push_exp("b2b", 32'hDEAD0002, 32'hDEAD0002);
    settle_and_check();

    // Write-enable gating
    @(negedge clk);
    rf_bus.write_enable  = 1'b0;
    rf_bus.write_address = 5'd7;
    rf_bus.write_data    = 32'h12345678;
    @(posedge clk);
    #1;
    set_reads(5'd7, 5'd0);
    push_exp("we_low", 32'h1000_0007, 32'h0);
    settle_and_check();
    do_write(5'd7, 32'h12345678);
    push_exp("we_high", 32'h12345678, 32'h0);
    settle_and_check();

    // Async reset mid-cycle, then a write held across an edge under reset
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    set_reads(5'd7, 5'd12);
    push_exp("async_rst", 32'h0, 32'h0);
    settle_and_check();
    rf_bus.write_enable  = 1'b1;
    rf_bus.write_address = 5'd7;
    rf_bus.write_data    = 32'hAAAA5555;
    set_reads(5'd7, 5'd7);
    push_exp("rst_rd_wr", 32'h0, 32'h0);
    settle_and_check();
    @(posedge clk);
    #1;
    rf_bus.write_enable = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    set_reads(5'd7, 5'd5);
    push_exp("rst_wins", 32'h0, 32'h0);
    settle_and_check();

    // Read during write
    do_write(5'd9, 32'h00000011);
    @(negedge clk);
    rf_bus.write_enable  = 1'b1;
    rf_bus.write_address = 5'd9;
    rf_bus.write_data    = 32'h00000022;
    set_reads(5'd9, 5'd8);
`ifdef REGFILE_BYPASS_EN
    push_exp("rdw_same", 32'h00000022, 32'h0);
`else
    push_exp("rdw_same", 32'h00000011, 32'h0);
`endif
    settle_and_check();
    @(posedge clk);
    #1;
    rf_bus.write_enable = 1'b0;
    model[9] = 32'h00000022;
    push_model("rdw_after");
    settle_and_check();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
